// File: rtl/serial_feed_pkg.sv
// -----------------------------------------------------------------------------
// serial_feed_pkg
//
// Shared definitions for the serial operand feeder:
//   - state_e      : controller state encoding (IDLE=0, CLEAR=1, SHIFT=2, DONE=3)
//   - feed_out_t   : bundle of the five registered controller outputs
//   - WIDTH_DEFAULT: default operand word length
//   - count_width(): bit counter width for a given operand width
//   - idle_outputs(): output values driven in IDLE and after reset
// -----------------------------------------------------------------------------
package serial_feed_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic clr_b;   // active-low clear to the downstream adder
        logic shift;   // shift enable to the downstream adder
        logic si;      // serial operand bit
        logic busy;    // controller not in IDLE
        logic done;    // completion pulse
    } feed_out_t;

    // The counter must hold WIDTH itself: it is still enabled on the last
    // SHIFT cycle and so steps one past the terminal value WIDTH-1.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic feed_out_t idle_outputs();
        feed_out_t o;
        o.clr_b = 1'b1;
        o.shift = 1'b0;
        o.si    = 1'b0;
        o.busy  = 1'b0;
        o.done  = 1'b0;
        return o;
    endfunction

endpackage : serial_feed_pkg

// File: rtl/serial_feed_ctrl_shift_count.sv
// -----------------------------------------------------------------------------
// shift_count
//
// Bit counter for the SHIFT phase. Synchronous clear has priority over the
// enable; the terminal-count flag is high while the count equals WIDTH-1,
// i.e. during the last bit of the operand.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   clr_i    : synchronous clear (count -> 0)
//   en_i     : count enable
//   count_o  : current count value
//   tc_o     : terminal-count flag (count == WIDTH-1)
// -----------------------------------------------------------------------------
module shift_count
    import serial_feed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == CW'(WIDTH - 1));

endmodule : shift_count

// File: rtl/serial_feed_ctrl.sv
// -----------------------------------------------------------------------------
// serial_feed_ctrl
//
// Streams one parallel operand, LSB first, into a downstream serial adder.
// Sequence per operation: CLEAR (1 cycle, clr_out_b low), SHIFT (WIDTH
// cycles, shift_control high, SI = held bit k), DONE (1 cycle, done high).
//
// Handshake: start is a request that is accepted only when the controller is
// idle (busy low); on acceptance data_in is captured and busy rises in the
// next cycle. A start while busy is high is dropped, not queued, and cannot
// disturb the captured operand.
//
// Ports:
//   CLK           : clock, rising edge
//   Clear_b       : synchronous active-low reset
//   start         : request to stream one operand
//   data_in       : parallel operand, captured on an accepted start
//   clr_out_b     : active-low clear to the serial adder
//   shift_control : shift enable to the serial adder (data-path enable only)
//   SI            : serial operand bit, LSB first
//   busy          : high in every state except IDLE
//   done          : one-cycle completion pulse
//
// Every output comes straight from a flop. The output register is loaded
// from the next state, so the outputs line up with the state they describe
// and no input reaches an output without passing through a register.
// -----------------------------------------------------------------------------
module serial_feed_ctrl
    import serial_feed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             clr_out_b,
    output logic             shift_control,
    output logic             SI,
    output logic             busy,
    output logic             done
);

    localparam int CW = count_width(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    feed_out_t        out_q;
    feed_out_t        out_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CW-1:0]    cnt_val;

    // Index of the operand bit that SI must carry in the coming cycle.
    logic [CW-1:0]    next_idx;
    logic [WIDTH-1:0] hold_shifted;

    shift_count #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shift_count (
        .clk_i   (CLK),
        .rst_ni  (Clear_b),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt_val),
        .tc_o    (cnt_tc)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hold_d  = data_in;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Clearing here makes the count read 0 in the first SHIFT cycle.
                cnt_clr = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-output logic (decoded from the next state)
    // -------------------------------------------------------------------------
    always_comb begin
        // Entering SHIFT from CLEAR starts at bit 0; staying in SHIFT moves to
        // the bit after the one currently on SI.
        next_idx = '0;
        if (state_q == ST_SHIFT) begin
            next_idx = cnt_val + CW'(1);
        end
    end

    // Shifting rather than indexing keeps the select width-agnostic.
    assign hold_shifted = hold_q >> next_idx;

    always_comb begin
        out_d = idle_outputs();

        case (state_d)
            ST_IDLE: begin
                out_d = idle_outputs();
            end
            ST_CLEAR: begin
                out_d.clr_b = 1'b0;
                out_d.busy  = 1'b1;
            end
            ST_SHIFT: begin
                out_d.shift = 1'b1;
                out_d.si    = hold_shifted[0];
                out_d.busy  = 1'b1;
            end
            ST_DONE: begin
                out_d.done  = 1'b1;
                out_d.busy  = 1'b1;
            end
            default: begin
                out_d = idle_outputs();
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!Clear_b) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            out_q   <= idle_outputs();
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
        end
    end

    assign clr_out_b     = out_q.clr_b;
    assign shift_control = out_q.shift;
    assign SI            = out_q.si;
    assign busy          = out_q.busy;
    assign done          = out_q.done;

endmodule : serial_feed_ctrl

// File: tb/tb_serial_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_feed_ctrl
//
// Directed and randomized checks of serial_feed_ctrl (WIDTH=4). A
// transaction-level model predicts the five outputs cycle by cycle: an
// accepted operation appends its whole output sequence to exp_q; reset
// discards whatever is still pending.
// -----------------------------------------------------------------------------
module tb_serial_feed_ctrl;

    localparam int W = 4;

    // Packed as {clr_out_b, shift_control, SI, busy, done}
    localparam logic [4:0] IDLE_V = 5'b1_0_0_0_0;

    logic         CLK;
    logic         Clear_b;
    logic         start;
    logic [W-1:0] data_in;
    logic         clr_out_b;
    logic         shift_control;
    logic         SI;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] cur_exp = IDLE_V;

    serial_feed_ctrl #(
        .WIDTH (W)
    ) dut (
        .CLK           (CLK),
        .Clear_b       (Clear_b),
        .start         (start),
        .data_in       (data_in),
        .clr_out_b     (clr_out_b),
        .shift_control (shift_control),
        .SI            (SI),
        .busy          (busy),
        .done          (done)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // -------------------------------------------------------------------------
    // Comparison helper
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // One clock: update the model at the rising edge with the inputs the DUT
    // samples there, then compare all outputs at the following falling edge.
    // -------------------------------------------------------------------------
    task automatic tick();
        logic [W-1:0] d;
        @(posedge CLK);
        if (!Clear_b) begin
            exp_q.delete();
        end else if (!cur_exp[1] && start) begin
            d = data_in;
            exp_q.push_back(5'b0_0_0_1_0);
            for (int k = 0; k < W; k++) begin
                exp_q.push_back({1'b1, 1'b1, d[k], 1'b1, 1'b0});
            end
            exp_q.push_back(5'b1_0_0_1_1);
        end
        cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
        @(negedge CLK);
        check("model", {27'd0, clr_out_b, shift_control, SI, busy, done}, {27'd0, cur_exp});
    endtask

    // One start pulse; returns in the cycle after the accepting edge.
    task automatic pulse_start(input logic [W-1:0] d);
        data_in = d;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Full operation with explicit timing checks relative to the start edge t.
    task automatic single_op(input logic [W-1:0] d);
        pulse_start(d);
        check("clear_low_t1", {31'd0, clr_out_b}, 32'd0);
        check("shift_off_t1", {31'd0, shift_control}, 32'd0);
        data_in = ~d;
        for (int k = 0; k < W; k++) begin
            tick();
            check("shift_on", {31'd0, shift_control}, 32'd1);
            check("si_bit", {31'd0, SI}, {31'd0, d[k]});
        end
        tick();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_no_shift", {31'd0, shift_control}, 32'd0);
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [W-1:0] op_a;
        logic [W-1:0] op_b;
        logic [W-1:0] chain_ops[2];
        logic [W-1:0] acc;
        int           shift_cnt;
        int           clr_cnt;
        int           done_cnt;

        op_a         = 4'b1011;
        op_b         = 4'b0110;
        chain_ops[0] = 4'b0011;
        chain_ops[1] = 4'b0101;

        Clear_b = 1'b0;
        start   = 1'b0;
        data_in = '0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_clr_out_b", {31'd0, clr_out_b}, 32'd1);
        check("rst_shift", {31'd0, shift_control}, 32'd0);
        check("rst_si", {31'd0, SI}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        Clear_b = 1'b1;
        tick();

        // Single operation, 1011 -> SI 1,1,0,1
        single_op(op_a);

        // Start held high through an operation, data_in changed after acceptance
        data_in = op_a;
        start   = 1'b1;
        tick();
        check("hold_clear", {31'd0, clr_out_b}, 32'd0);
        data_in = op_b;
        for (int k = 0; k < W; k++) begin
            tick();
            check("hold_si", {31'd0, SI}, {31'd0, op_a[k]});
            check("hold_no_clear", {31'd0, clr_out_b}, 32'd1);
        end
        tick();
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_done_no_clear", {31'd0, clr_out_b}, 32'd1);
        tick();
        check("hold_idle", {31'd0, busy}, 32'd0);
        check("hold_idle_no_clear", {31'd0, clr_out_b}, 32'd1);
        tick();
        check("hold_reclear", {31'd0, clr_out_b}, 32'd0);
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            tick();
            check("hold2_si", {31'd0, SI}, {31'd0, op_b[k]});
        end
        tick();
        check("hold2_done", {31'd0, done}, 32'd1);
        tick();

        // Reset at the second SHIFT cycle
        pulse_start(op_a);
        tick();
        check("mid_shift1", {31'd0, shift_control}, 32'd1);
        tick();
        check("mid_shift2", {31'd0, shift_control}, 32'd1);
        Clear_b = 1'b0;
        tick();
        Clear_b = 1'b1;
        check("mid_rst_shift", {31'd0, shift_control}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_clr", {31'd0, clr_out_b}, 32'd1);
        done_cnt = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 32'd0);
        single_op(op_a);

        // Reset and start at the same edge
        Clear_b = 1'b0;
        start   = 1'b1;
        data_in = op_a;
        tick();
        check("prio_busy", {31'd0, busy}, 32'd0);
        check("prio_clr", {31'd0, clr_out_b}, 32'd1);
        Clear_b = 1'b1;
        start   = 1'b0;
        tick();
        check("prio_still_idle", {31'd0, busy}, 32'd0);
        check("prio_no_clear", {31'd0, clr_out_b}, 32'd1);

        // Two chained operations into a serial-shift-register stand-in
        clr_cnt = 0;
        for (int op = 0; op < 2; op++) begin
            shift_cnt = 0;
            acc       = '0;
            pulse_start(chain_ops[op]);
            if (!clr_out_b) clr_cnt++;
            for (int i = 0; i < W + 2; i++) begin
                tick();
                if (!clr_out_b) clr_cnt++;
                if (shift_control) begin
                    shift_cnt++;
                    acc = {SI, acc[W-1:1]};
                end
            end
            check("chain_shift_cycles", shift_cnt, W);
            check("chain_operand", {28'd0, acc}, {28'd0, chain_ops[op]});
        end
        check("chain_clear_pulses", clr_cnt, 32'd2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            start   = ($urandom_range(0, 2) == 0);
            data_in = W'($urandom_range(0, (1 << W) - 1));
            Clear_b = ($urandom_range(0, 39) != 0);
            tick();
        end
        Clear_b = 1'b1;
        start   = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
        end
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_feed_ctrl
